door_event_encoder: RTL and testbench

- Drives the occupancy counter's `switch` and `UporDown` inputs in the bank-lobby system. It is the event producer for that counter.
- Watches two door light-barrier sensors (outer and inner). It synchronises and debounces them, then decodes the direction of each complete walk-through.
- Each valid passage becomes one single-cycle step pulse with a direction level. The direction is set up one cycle before the pulse.
- Keeps a shadow occupancy count and suppresses steps that would take the 3-bit counter past 7 or below 0.

---
 rtl/door_event_encoder_pkg.sv | 27 ++
 rtl/door_event_encoder_debounce.sv | 38 +++
 rtl/door_event_encoder.sv | 125 ++++++++++++
 tb/tb_door_event_encoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/door_event_encoder_pkg.sv
// rtl/door_event_encoder_pkg.sv - shared encodings for the door event encoder
package door_event_encoder_pkg;

    localparam int OCC_W = 3;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EN1  = 3'd1;
    localparam logic [2:0] ST_EN2  = 3'd2;
    localparam logic [2:0] ST_EN3  = 3'd3;
    localparam logic [2:0] ST_EX1  = 3'd4;
    localparam logic [2:0] ST_EX2  = 3'd5;
    localparam logic [2:0] ST_EX3  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        EN1  = ST_EN1,
        EN2  = ST_EN2,
        EN3  = ST_EN3,
        EX1  = ST_EX1,
        EX2  = ST_EX2,
        EX3  = ST_EX3
    } state_t;

endpackage

// File: rtl/door_event_encoder_debounce.sv
// rtl/door_event_encoder_debounce.sv - two-flop synchroniser plus stability-count debouncer
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic clean
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any sample agreeing with the current level restarts the run.
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/door_event_encoder.sv
// rtl/door_event_encoder.sv - decodes door passages into gated step/direction events for the occupancy counter
module door_event_encoder
    import door_event_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int MAX_OCC         = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sens_out,
    input  logic             sens_in,
    output logic             step,
    output logic             up_dn,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic             a_clean;
    logic             b_clean;
    logic [1:0]       code;
    state_t           state;
    state_t           state_nxt;
    logic             ev_up;
    logic             ev_dn;
    logic             accept;
    logic             timeout;
    logic             pend;
    logic [TW-1:0]    tcnt;
    logic [OCC_W-1:0] occ_nxt;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_out (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sens_out),
        .clean   (a_clean)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sens_in),
        .clean   (b_clean)
    );

    assign code = {a_clean, b_clean};

    always_comb begin
        state_nxt = state;
        ev_up     = 1'b0;
        ev_dn     = 1'b0;
        case (state)
            IDLE: if (code == 2'b10) state_nxt = EN1;
                  else if (code == 2'b01) state_nxt = EX1;
            EN1:  if (code == 2'b11) state_nxt = EN2;
                  else if (code == 2'b00) state_nxt = IDLE;
            EN2:  if (code == 2'b01) state_nxt = EN3;
                  else if (code == 2'b10) state_nxt = EN1;
            EN3:  if (code == 2'b00) begin
                      state_nxt = IDLE;
                      ev_up     = 1'b1;
                  end else if (code == 2'b11) state_nxt = EN2;
            EX1:  if (code == 2'b11) state_nxt = EX2;
                  else if (code == 2'b00) state_nxt = IDLE;
            EX2:  if (code == 2'b10) state_nxt = EX3;
                  else if (code == 2'b01) state_nxt = EX1;
            EX3:  if (code == 2'b00) begin
                      state_nxt = IDLE;
                      ev_dn     = 1'b1;
                  end else if (code == 2'b11) state_nxt = EX2;
            default: state_nxt = IDLE;
        endcase
    end

    // A real transition on the limit cycle wins over the timeout.
    assign timeout = (state != IDLE) && (state_nxt == state)
                     && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign accept  = (ev_up && !full) || (ev_dn && !empty);
    assign occ_nxt = (up_dn == DIR_UP) ? occupancy + OCC_W'(1) : occupancy - OCC_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            err <= timeout;
            if (timeout) begin
                state <= IDLE;
                tcnt  <= '0;
            end else begin
                state <= state_nxt;
                if ((state_nxt != state) || (state == IDLE)) tcnt <= '0;
                else tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Direction lands one edge ahead of the step so the counter sees it settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            step      <= 1'b0;
            up_dn     <= DIR_DN;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            pend <= accept;
            step <= pend;
            if (accept) up_dn <= ev_up ? DIR_UP : DIR_DN;
            if (pend) begin
                occupancy <= occ_nxt;
                full      <= (occ_nxt == OCC_W'(MAX_OCC));
                empty     <= (occ_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_door_event_encoder.sv
// tb/tb_door_event_encoder.sv - self-checking bench with a passage-level reference model
module tb_door_event_encoder;

    localparam int D = 4;
    localparam int T = 64;
    localparam int M = 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sens_out = 1'b0;
    logic       sens_in = 1'b0;
    logic       step;
    logic       up_dn;
    logic [2:0] occupancy;
    logic       full;
    logic       empty;
    logic       err;

    door_event_encoder #(
        .DEBOUNCE_CYCLES (D),
        .TIMEOUT_CYCLES  (T),
        .MAX_OCC         (M)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sens_out  (sens_out),
        .sens_in   (sens_in),
        .step      (step),
        .up_dn     (up_dn),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int step_cnt = 0;
    int err_cnt = 0;
    int step_edge = 0;
    int c0 = 0;
    int prev_up = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: passage position along an ordered code path per direction.
    int m_dir = 0;   // 0 idle, 1 entering, 2 exiting
    int m_pos = 0;   // codes of the path already matched (1..3)
    int m_age = 0;
    int m_pend = 0;
    int m_step = 0;
    int m_up = 0;
    int m_occ = 0;
    int m_err = 0;
    int ca = 0;
    int cb = 0;
    int ra[D+2];
    int rb[D+2];
    int code, nd, np, ev, evdir, acc, alla, allb;

    function automatic int seq_code(input int d, input int i);
        if (d == 1) begin
            case (i) 0: return 2; 1: return 3; 2: return 1; default: return 0; endcase
        end
        case (i) 0: return 1; 1: return 3; 2: return 2; default: return 0; endcase
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dir = 0; m_pos = 0; m_age = 0; m_pend = 0; m_step = 0;
            m_up = 0; m_occ = 0; m_err = 0; ca = 0; cb = 0;
            for (int j = 0; j < D + 2; j++) begin ra[j] = 0; rb[j] = 0; end
        end else begin
            code = ca * 2 + cb;
            nd = m_dir; np = m_pos; ev = 0; evdir = 0;
            if (m_dir == 0) begin
                if (code == 2) begin nd = 1; np = 1; end
                else if (code == 1) begin nd = 2; np = 1; end
            end else if (code == seq_code(m_dir, m_pos)) begin
                if (m_pos == 3) begin ev = 1; evdir = m_dir; nd = 0; np = 0; end
                else np = m_pos + 1;
            end else if (code == ((m_pos == 1) ? 0 : seq_code(m_dir, m_pos - 2))) begin
                if (m_pos == 1) begin nd = 0; np = 0; end
                else np = m_pos - 1;
            end
            m_err = 0;
            if (nd != m_dir || np != m_pos) m_age = 0;
            else if (m_dir != 0) begin
                m_age++;
                if (m_age == T) begin nd = 0; np = 0; m_age = 0; m_err = 1; end
            end
            m_dir = nd; m_pos = np;

            acc = ev && ((evdir == 1 && m_occ != M) || (evdir == 2 && m_occ != 0));
            m_step = m_pend;
            if (m_pend) m_occ = m_up ? m_occ + 1 : m_occ - 1;
            m_pend = 0;
            if (acc) begin m_up = (evdir == 1); m_pend = 1; end

            for (int j = D + 1; j > 0; j--) begin ra[j] = ra[j-1]; rb[j] = rb[j-1]; end
            ra[0] = sens_out; rb[0] = sens_in;
            alla = 1; allb = 1;
            for (int j = 2; j < D + 2; j++) begin
                if (ra[j] == ca) alla = 0;
                if (rb[j] == cb) allb = 0;
            end
            if (alla) ca = 1 - ca;
            if (allb) cb = 1 - cb;
        end
    end

    always @(negedge clk) begin
        check("step", step, m_step);
        check("up_dn", up_dn, m_up);
        check("occupancy", occupancy, m_occ);
        check("full", full, m_occ == M);
        check("empty", empty, m_occ == 0);
        check("err", err, m_err);
        if (step) begin
            check("up_dn_setup", up_dn, prev_up);
            step_cnt++;
            step_edge = cyc;
        end
        if (err) err_cnt++;
        prev_up = up_dn;
    end

    task automatic hold(input bit a, input bit b, input int n);
        sens_out = a;
        sens_in  = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_pass(input bit entry);
        if (entry) begin hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); end
        else       begin hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); end
        c0 = cyc;
        hold(0, 0, 20);
    endtask

    int s0;
    int got;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_up_dn", up_dn, 0);
        check("rst_occ", occupancy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_err", err, 0);
        reset_n = 1'b1;
        hold(0, 0, 5);

        s0 = step_cnt;
        do_pass(1);
        check("entry_steps", step_cnt - s0, 1);
        check("entry_latency", step_edge - c0, 8);
        check("entry_occ", occupancy, 1);
        check("entry_empty", empty, 0);
        check("entry_dir", up_dn, 1);

        do_pass(1);
        do_pass(1);
        check("three_occ", occupancy, 3);
        do_pass(0);
        check("exit_occ", occupancy, 2);
        check("exit_dir", up_dn, 0);
        check("exit_latency", step_edge - c0, 8);

        s0 = step_cnt;
        hold(1, 0, 20);
        hold(0, 0, 20);
        for (int i = 0; i < 15; i++) hold(i % 2 == 0, 0, 2);
        hold(0, 0, 20);
        check("backout_bounce_steps", step_cnt - s0, 0);
        check("backout_bounce_occ", occupancy, 2);

        do_pass(0);
        do_pass(0);
        s0 = step_cnt;
        for (int i = 0; i < 8; i++) do_pass(1);
        check("sat_steps", step_cnt - s0, 7);
        check("sat_occ", occupancy, 7);
        check("sat_full", full, 1);
        s0 = step_cnt;
        for (int i = 0; i < 8; i++) do_pass(0);
        check("drain_steps", step_cnt - s0, 7);
        check("drain_empty", empty, 1);

        s0 = err_cnt;
        got = step_cnt;
        hold(1, 0, 20);
        hold(1, 1, 80);
        hold(0, 0, 20);
        check("timeout_err", err_cnt - s0, 1);
        check("timeout_steps", step_cnt - got, 0);
        check("timeout_occ", occupancy, 0);

        hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20);
        sens_out = 0; sens_in = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (step) got = 1;
        end
        check("reset_step_seen", got, 1);
        reset_n = 1'b0;
        #1;
        check("reset_async_step", step, 0);
        check("reset_async_occ", occupancy, 0);
        check("reset_async_up_dn", up_dn, 0);
        @(negedge clk);
        hold(0, 0, 3);
        reset_n = 1'b1;
        hold(0, 0, 5);

        for (int i = 0; i < 250; i++) begin
            got = $urandom_range(0, 3);
            hold(got[1], got[0], $urandom_range(1, 30));
        end
        hold(0, 0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
